// File: rtl/mux3_arbiter.sv
`default_nettype none
// ============================================================================
// mux3_arbiter : round-robin arbiter with bounded hold for the mux3 bus select
// Revision 1.0 : initial release
// ============================================================================
module mux3_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_i,
   output logic [7:0] grant_o,
   output logic [2:0] sel_o,
   output logic       busy_o,
   output logic       preempt_o
);

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] sel_q, sel_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] hold_q, hold_d;
   logic       busy_q, busy_d;
   logic       preempt_q, preempt_d;

   logic [7:0] cand;
   logic [2:0] win;
   logic [2:0] idx;
   logic       found;
   logic       owner_req;
   logic       others;
   logic       do_preempt;

   // Current owner never competes in the scan; on release its bit is low anyway
   always_comb begin
      cand  = req_i & ~grant_q;
      win   = 3'd0;
      idx   = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr_q + 3'(i);
         if (!found && cand[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign owner_req  = |(req_i & grant_q);
   assign others     = |cand;
   assign do_preempt = (state_q == S_OWN) && owner_req && others &&
                       (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      if (((state_q == S_IDLE) && found) ||
          ((state_q == S_OWN) && !owner_req && found) || do_preempt) begin
         state_d   = S_OWN;
         grant_d   = 8'(1) << win;
         sel_d     = win;
         ptr_d     = win + 3'd1;
         hold_d    = 8'd0;
         preempt_d = do_preempt;
      end else if ((state_q == S_OWN) && !owner_req) begin
         state_d = S_IDLE;
         grant_d = 8'd0;
         hold_d  = 8'd0;
      end else if (state_q == S_OWN) begin
         // Hold time only accrues while someone else is waiting
         if (others)
            hold_d = (hold_q == HOLD_LIM) ? hold_q : hold_q + 8'd1;
         else
            hold_d = 8'd0;
      end
      busy_d = |grant_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= 8'd0;
         sel_q     <= 3'd0;
         ptr_q     <= 3'd0;
         hold_q    <= 8'd0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
      end
   end

   assign grant_o   = grant_q;
   assign sel_o     = sel_q;
   assign busy_o    = busy_q;
   assign preempt_o = preempt_q;

endmodule
`default_nettype wire
